// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int IM_LO   = 10;
  localparam int IP_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int EXC_LO  = 2;
  localparam int EXC_W   = 5;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_irq_arb.sv
// Interrupt/exception arbitration: pending detection, EXL gating and code priority.
module cp0_irq_arb
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int HWINT_W = 6
) (
  input  logic               exl_i,
  input  logic               ie_i,
  input  logic [HWINT_W-1:0] im_i,
  input  logic [HWINT_W-1:0] hwint_i,
  input  logic [4:0]         exc_code_i,
  output logic               int_req_o,
  output logic [4:0]         rec_code_o
);

  logic int_pend;
  logic exc_pend;

  always_comb begin
    int_pend   = ie_i & (|(hwint_i & im_i));
    exc_pend   = (exc_code_i != EXC_INT);
    int_req_o  = ~exl_i & (int_pend | exc_pend);
    // Interrupts outrank a synchronous exception in the same instruction.
    rec_code_o = int_pend ? EXC_INT : exc_code_i;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage (SR, Cause, EPC, PRId).
// Define CP0_BADVADDR_EN to add BadVAddr (register 8) and the BadAddr_M port.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_7000,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               WE,
  input  logic [31:0]        PC_M,
  input  logic               BD_M,
  input  logic [4:0]         ExcCode_M,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0]        BadAddr_M,
`endif
  output logic               IntReq,
  output logic [31:0]        EPC,
  output logic [31:0]        DOut
);

  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [4:0]         exc_q, exc_d;
  logic [31:0]        epc_q, epc_d;
`ifdef CP0_BADVADDR_EN
  logic [31:0]        badvaddr_q, badvaddr_d;
`endif

  logic        int_req;
  logic [4:0]  rec_code;
  logic [31:0] victim_pc;
  logic [31:0] sr_rd;
  logic [31:0] cause_rd;

  cp0_irq_arb #(.HWINT_W(HWINT_W)) u_arb (
    .exl_i      (exl_q),
    .ie_i       (ie_q),
    .im_i       (im_q),
    .hwint_i    (HWInt),
    .exc_code_i (ExcCode_M),
    .int_req_o  (int_req),
    .rec_code_o (rec_code)
  );

  assign IntReq    = int_req;
  assign EPC       = epc_q;
  assign victim_pc = BD_M ? (PC_M - 32'd4) : PC_M;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = HWInt;
`ifdef CP0_BADVADDR_EN
    badvaddr_d = badvaddr_q;
`endif
    if (int_req) begin
      // The victim is flushed, so any mtc0 or eret it carries is discarded.
      exl_d = 1'b1;
      bd_d  = BD_M;
      exc_d = rec_code;
      epc_d = {victim_pc[31:2], 2'b00};
`ifdef CP0_BADVADDR_EN
      if (is_addr_exc(rec_code)) badvaddr_d = BadAddr_M;
`endif
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[IM_LO +: HWINT_W];
        exl_d = DIn[EXL_BIT];
        ie_d  = DIn[IE_BIT];
      end
      if (WE && (A2 == REG_EPC)) epc_d = {DIn[31:2], 2'b00};
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= '0;
`endif
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
`ifdef CP0_BADVADDR_EN
      badvaddr_q <= badvaddr_d;
`endif
    end
  end

  always_comb begin
    sr_rd                      = '0;
    sr_rd[IM_LO +: HWINT_W]    = im_q;
    sr_rd[EXL_BIT]             = exl_q;
    sr_rd[IE_BIT]              = ie_q;
    cause_rd                   = '0;
    cause_rd[BD_BIT]           = bd_q;
    cause_rd[IP_LO +: HWINT_W] = ip_q;
    cause_rd[EXC_LO +: EXC_W]  = exc_q;
  end

  always_comb begin
    DOut = '0;
    case (A1)
      REG_SR:       DOut = sr_rd;
      REG_CAUSE:    DOut = cause_rd;
      REG_EPC:      DOut = epc_q;
      REG_PRID:     DOut = PRID_VALUE;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: DOut = badvaddr_q;
`endif
      default:      DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed, table-driven bench for cp0_exc_ctrl plus a reset-vs-IntReq sequence.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] BadAddr_M;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
`ifdef CP0_BADVADDR_EN
    .BadAddr_M (BadAddr_M),
`endif
    .IntReq    (IntReq),
    .EPC       (EPC),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_ir;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [4:0] a1, input logic we, input logic [4:0] a2,
                              input logic [31:0] din, input logic [31:0] pc, input logic bd,
                              input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                              input logic exp_ir, input logic [31:0] exp_dout,
                              input logic [31:0] exp_epc);
    vec_t v;
    v.a1 = a1; v.we = we; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr;
    v.exp_ir = exp_ir; v.exp_dout = exp_dout; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  initial begin
    logic [31:0] badv_exp;
`ifdef CP0_BADVADDR_EN
    badv_exp = 32'h0000_0003;
`else
    badv_exp = 32'h0000_0000;
`endif

    //            a1  we a2  din           pc            bd exc hw       clr ir dout          epc
    vecs[0]  = mk(12, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0, 0, 32'h0,        32'h0);
    vecs[1]  = mk(13, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0, 0, 32'h0,        32'h0);
    vecs[2]  = mk(14, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0, 0, 32'h0,        32'h0);
    vecs[3]  = mk(15, 0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0, 0, 32'h0000_7000, 32'h0);
    vecs[4]  = mk(8,  0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 0, 0, 32'h0,        32'h0);
    vecs[5]  = mk(12, 1, 12, 32'h0000_0401, 32'h0,       0, 0,  6'h00, 0, 0, 32'h0000_0401, 32'h0);
    vecs[6]  = mk(12, 0, 0,  32'h0,        32'h0000_3010, 0, 0,  6'h01, 0, 1, 32'h0000_0403, 32'h0000_3010);
    vecs[7]  = mk(13, 0, 0,  32'h0,        32'h0000_3010, 0, 0,  6'h00, 0, 0, 32'h0,        32'h0000_3010);
    vecs[8]  = mk(12, 0, 0,  32'h0,        32'h0000_3010, 0, 0,  6'h00, 1, 0, 32'h0000_0401, 32'h0000_3010);
    vecs[9]  = mk(13, 0, 0,  32'h0,        32'h0000_3024, 1, 12, 6'h00, 0, 1, 32'h8000_0030, 32'h0000_3020);
    vecs[10] = mk(13, 0, 0,  32'h0,        32'h0000_3024, 1, 10, 6'h3F, 0, 0, 32'h8000_FC30, 32'h0000_3020);
    vecs[11] = mk(12, 0, 0,  32'h0,        32'h0000_3024, 1, 10, 6'h3F, 1, 0, 32'h0000_0401, 32'h0000_3020);
    vecs[12] = mk(14, 1, 14, 32'h0000_4000, 32'h0000_5000, 0, 0,  6'h01, 0, 1, 32'h0000_5000, 32'h0000_5000);
    vecs[13] = mk(12, 0, 0,  32'h0,        32'h0000_5000, 0, 0,  6'h00, 1, 0, 32'h0000_0401, 32'h0000_5000);
    vecs[14] = mk(14, 1, 14, 32'h0000_4000, 32'h0000_5000, 0, 0,  6'h00, 0, 0, 32'h0000_4000, 32'h0000_4000);
    vecs[15] = mk(13, 0, 0,  32'h0,        32'h0000_6000, 0, 4,  6'h01, 0, 1, 32'h0000_0400, 32'h0000_6000);
    vecs[16] = mk(8,  0, 0,  32'h0,        32'h0000_6000, 0, 0,  6'h00, 1, 0, 32'h0,        32'h0000_6000);
    vecs[17] = mk(13, 1, 13, 32'hFFFF_FFFF, 32'h0000_6000, 0, 0,  6'h00, 0, 0, 32'h0,        32'h0000_6000);
    vecs[18] = mk(14, 0, 0,  32'h0,        32'h0,        1, 4,  6'h00, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vecs[19] = mk(8,  0, 0,  32'h0,        32'h0,        0, 0,  6'h00, 1, 0, badv_exp,     32'hFFFF_FFFC);
    vecs[20] = mk(12, 1, 12, 32'h0000_0403, 32'h0,       0, 0,  6'h00, 1, 0, 32'h0000_0401, 32'hFFFF_FFFC);
    vecs[21] = mk(12, 0, 0,  32'h0,        32'h0000_7000, 0, 12, 6'h00, 1, 1, 32'h0000_0403, 32'h0000_7000);
    vecs[22] = mk(12, 0, 0,  32'h0,        32'h0000_7000, 0, 0,  6'h00, 1, 0, 32'h0000_0401, 32'h0000_7000);

    reset = 1'b1; A1 = 0; A2 = 0; DIn = 0; WE = 0; PC_M = 0; BD_M = 0;
    ExcCode_M = 0; HWInt = 0; EXLClr = 0; BadAddr_M = 32'h0000_0003;
    repeat (2) @(posedge clk);
    #1;
    check("reset_intreq", {31'b0, IntReq}, 32'h0);
    check("reset_epc", EPC, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      A1 = vecs[i].a1; WE = vecs[i].we; A2 = vecs[i].a2; DIn = vecs[i].din;
      PC_M = vecs[i].pc; BD_M = vecs[i].bd; ExcCode_M = vecs[i].exc;
      HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
      #1;
      check($sformatf("v%0d_intreq", i), {31'b0, IntReq}, {31'b0, vecs[i].exp_ir});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_dout_a1_%0d", i, vecs[i].a1), DOut, vecs[i].exp_dout);
      check($sformatf("v%0d_epc", i), EPC, vecs[i].exp_epc);
    end

    // Reset coinciding with a live IntReq must clear everything.
    WE = 0; EXLClr = 0; HWInt = 0; BD_M = 0; ExcCode_M = 5'd10; PC_M = 32'h0000_8000; A1 = 12;
    #1;
    check("rst_race_intreq_pre", {31'b0, IntReq}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ExcCode_M = 0;
    check("rst_race_sr", DOut, 32'h0);
    check("rst_race_epc", EPC, 32'h0);
    A1 = 13;
    #1;
    check("rst_race_cause", DOut, 32'h0);
    check("rst_race_intreq_post", {31'b0, IntReq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the M stage and generates the IntReq flush that clears the pipeline registers. It also latches the victim PC into EPC and supplies EPC to the fetch stage for eret.
- Holds SR, Cause, EPC and PRId.
- Serves mfc0 reads and mtc0 writes.
- Sets and clears the exception level (EXL) that gates further requests.

Parameters:
PRID_VALUE, 32'h0000_7000, constant returned on reads of register 15.
HWINT_W, 6, number of hardware interrupt lines (maps to SR.IM / Cause.IP bits [15:10]).

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
A1  input  5  mfc0 read register number
A2  input  5  mtc0 write register number
DIn  input  32  mtc0 write data (M-stage rt value)
WE  input  1  mtc0 write enable (M stage)
PC_M  input  32  PC of the instruction in M
BD_M  input  1  instruction in M is in a branch delay slot
ExcCode_M  input  5  exception code of the M instruction; 0 = none
HWInt  input  6  hardware interrupt lines, level-sensitive
EXLClr  input  1  eret in M; clears SR.EXL
IntReq  output  1  flush/redirect request to all pipeline registers and PC
EPC  output  32  current EPC value, used as the eret target
DOut  output  32  mfc0 read data

Behaviour:
- Register fields:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): full 32 bits, bits [1:0] forced to 0.
  - PRId (15): reads PRID_VALUE.
- Reset: SR, Cause and EPC all = 0, so IntReq = 0 and DOut = 0 for A1 in {12, 13, 14}.
- IntReq is combinational and is 0 whenever SR.EXL = 1. Otherwise:
  - int_pend = IE & |(HWInt & IM)
  - exc_pend = (ExcCode_M != 0)
  - IntReq = int_pend | exc_pend
- Priority: an interrupt takes precedence over an exception. The recorded code is 0 if int_pend, else ExcCode_M.
- On a clock edge with IntReq = 1:
  - SR.EXL <= 1.
  - Cause.BD <= BD_M.
  - Cause.ExcCode <= recorded code.
  - EPC <= (BD_M ? PC_M - 4 : PC_M), word aligned.
  - Any mtc0 in the same cycle is dropped, because the victim instruction is discarded.
- Cause.IP <= HWInt every cycle, regardless of EXL, WE or IntReq.
- mtc0 (WE = 1 and IntReq = 0), one-cycle latency:
  - A2 = 12 writes IM, EXL and IE.
  - A2 = 14 writes EPC.
  - Writes to A2 = 13, A2 = 15 or any other number are ignored.
- EXLClr = 1 and IntReq = 0: SR.EXL <= 0 at the edge. If an mtc0 to SR lands in the same cycle, EXLClr wins for the EXL bit only.
- EXLClr and IntReq cannot both be effective in one cycle, since IntReq is gated by EXL = 1 during eret. If both are asserted anyway, IntReq wins.
- DOut is combinational from the registered state (no write bypass). Unmapped numbers read 0.
- Reset asserted together with IntReq: reset wins and all state is cleared.
- PC_M - 4 wraps modulo 2^32.

Optional Feature:
- Macro CP0_BADVADDR_EN.
- Defined:
  - Adds register 8, BadVAddr, with input port BadAddr_M [31:0].
  - BadVAddr is loaded with BadAddr_M on an IntReq edge whose recorded code is 4 (AdEL) or 5 (AdES).
  - Reset value 0; read-only to mtc0.
- Undefined: the BadAddr_M port is absent and A1 = 8 reads 0.

Decomposition:
- Shared package/header holds:
  - register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15, BADVADDR = 8;
  - ExcCode constants: INT = 0, ADEL = 4, ADES = 5, RI = 10, OV = 12;
  - field bit positions for IM, IP, EXL, IE, BD and ExcCode.
- Sub-module cp0_irq_arb: combinational int_pend/exc_pend/priority logic producing IntReq and the recorded code.

Test Plan:
1. Reset, then read A1 = 12/13/14/15 -> DOut = 0/0/0/32'h0000_7000; IntReq = 0.
2. mtc0 SR = 32'h0000_0401 (IM[10] = 1, IE = 1), then HWInt = 6'b000001, PC_M = 32'h0000_3010, BD_M = 0 -> IntReq = 1 the same cycle; next cycle EPC = 32'h0000_3010, Cause.ExcCode = 0, SR.EXL = 1, IntReq = 0.
3. With EXL = 0, ExcCode_M = 12, BD_M = 1, PC_M = 32'h0000_3024 -> next cycle EPC = 32'h0000_3020, Cause = 32'h8000_0030 (BD = 1, ExcCode = 12), assuming HWInt = 0.
4. With EXL = 1, HWInt = 6'b111111 and ExcCode_M = 10 -> IntReq stays 0. Pulse EXLClr -> next cycle SR.EXL = 0 and IntReq = 1 (IE = 1, IM[10] = 1).
5. Same cycle: WE = 1, A2 = 14, DIn = 32'h0000_4000, and an interrupt pending -> EPC = victim PC, not 32'h0000_4000. With no interrupt, the same write sets EPC = 32'h0000_4000.
6. Interrupt and ExcCode_M = 4 together -> recorded code 0. With CP0_BADVADDR_EN and an AdEL-only trap, BadAddr_M = 32'h0000_0003 -> A1 = 8 reads 32'h0000_0003.
